// File: rtl/sync_ctrl.sv
// Acquisition sequencer: flushes, arms short detection, windows long-preamble lock,
// then holds the receive chain in demod until the decoder finishes, aborts or times out.
module sync_ctrl #(
    parameter int RESET_CYCLES = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sample_in_strobe,
    input  logic                 short_preamble_detected,
    input  logic                 long_preamble_detected,
    input  logic                 demod_done,
    input  logic                 demod_abort,
    input  logic [15:0]          long_timeout,
    input  logic [23:0]          max_pkt_samples,
    output logic                 sync_short_reset,
    output logic                 sync_short_enable,
    output logic                 sync_long_reset,
    output logic                 sync_long_enable,
    output logic                 demod_is_ongoing,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] false_trigger_count,
    output logic [CNT_WIDTH-1:0] abort_count
);

    localparam int FW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_FLUSH     = 2'd0,
        S_SEARCH    = 2'd1,
        S_WAIT_LONG = 2'd2,
        S_DEMOD     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          flush_q, flush_d;
    logic [23:0]            timer_q, timer_d;
    logic [CNT_WIDTH-1:0]   pkt_q, false_q, abort_q;
    logic                   inc_pkt, inc_false, inc_abort;
    logic                   short_rst_d, short_en_d, long_rst_d, long_en_d, demod_d;
    logic [23:0]            long_limit, pkt_limit;

    // Both limits compare against (limit - 1) so the exit happens on the limit-th sample.
    assign long_limit = {8'd0, long_timeout} - 24'd1;
    assign pkt_limit  = max_pkt_samples - 24'd1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic inc);
        return (inc && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        timer_d   = timer_q;
        inc_pkt   = 1'b0;
        inc_false = 1'b0;
        inc_abort = 1'b0;
        if (enable) begin
            unique case (state_q)
                S_FLUSH: begin
                    if (flush_q == FW'(RESET_CYCLES - 1)) begin
                        state_d = S_SEARCH;
                        flush_d = '0;
                    end else begin
                        flush_d = flush_q + FW'(1);
                    end
                end
                S_SEARCH: begin
                    if (short_preamble_detected) begin
                        state_d = S_WAIT_LONG;
                        timer_d = '0;
                    end
                end
                S_WAIT_LONG: begin
                    if (long_preamble_detected) begin
                        state_d = S_DEMOD;
                        timer_d = '0;
                    end else if (sample_in_strobe) begin
                        if ((long_timeout != '0) && (timer_q == long_limit)) begin
                            state_d   = S_FLUSH;
                            inc_false = 1'b1;
                        end else if (timer_q != '1) begin
                            timer_d = timer_q + 24'd1;
                        end
                    end
                end
                S_DEMOD: begin
                    if (demod_abort) begin
                        state_d   = S_FLUSH;
                        inc_abort = 1'b1;
                    end else if (demod_done) begin
                        state_d = S_FLUSH;
                        inc_pkt = 1'b1;
                    end else if (sample_in_strobe) begin
                        if ((max_pkt_samples != '0) && (timer_q == pkt_limit)) begin
                            state_d   = S_FLUSH;
                            inc_abort = 1'b1;
                        end else if (timer_q != '1) begin
                            timer_d = timer_q + 24'd1;
                        end
                    end
                end
                default: state_d = S_FLUSH;
            endcase
        end
    end

    // Stage controls are decoded from the next state so they change on the transition edge.
    always_comb begin
        short_rst_d = 1'b0;
        short_en_d  = 1'b1;
        long_rst_d  = 1'b0;
        long_en_d   = 1'b1;
        demod_d     = 1'b0;
        unique case (state_d)
            S_FLUSH: begin
                short_rst_d = 1'b1;
                short_en_d  = 1'b0;
                long_rst_d  = 1'b1;
                long_en_d   = 1'b0;
            end
            S_SEARCH: begin
                long_rst_d = 1'b1;
                long_en_d  = 1'b0;
            end
            S_WAIT_LONG: ;
            S_DEMOD:     demod_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= S_FLUSH;
            flush_q           <= '0;
            timer_q           <= '0;
            pkt_q             <= '0;
            false_q           <= '0;
            abort_q           <= '0;
            sync_short_reset  <= 1'b1;
            sync_short_enable <= 1'b0;
            sync_long_reset   <= 1'b1;
            sync_long_enable  <= 1'b0;
            demod_is_ongoing  <= 1'b0;
        end else begin
            state_q           <= state_d;
            flush_q           <= flush_d;
            timer_q           <= timer_d;
            pkt_q             <= sat_inc(pkt_q, inc_pkt);
            false_q           <= sat_inc(false_q, inc_false);
            abort_q           <= sat_inc(abort_q, inc_abort);
            sync_short_reset  <= short_rst_d;
            sync_short_enable <= short_en_d;
            sync_long_reset   <= long_rst_d;
            sync_long_enable  <= long_en_d;
            demod_is_ongoing  <= demod_d;
        end
    end

    assign state               = state_q;
    assign pkt_count           = pkt_q;
    assign false_trigger_count = false_q;
    assign abort_count         = abort_q;

endmodule

// File: tb/tb_sync_ctrl.sv
// Directed bench for sync_ctrl; a second instance with 2-bit counters shows saturation.
module tb_sync_ctrl;

    logic        clock = 1'b0;
    logic        reset, enable, strobe, short_det, long_det, done, abort;
    logic [15:0] long_timeout;
    logic [23:0] max_pkt;
    logic        sr, se, lr, le, demod;
    logic [1:0]  state;
    logic [15:0] pkt, fals, abrt;
    logic        s_sr, s_se, s_lr, s_le, s_demod;
    logic [1:0]  s_state;
    logic [1:0]  s_pkt, s_fals, s_abrt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_pkt  = 0;
    int exp_fals = 0;
    int exp_abrt = 0;

    always #5 clock = ~clock;

    sync_ctrl #(.RESET_CYCLES(5), .CNT_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .sample_in_strobe(strobe),
        .short_preamble_detected(short_det), .long_preamble_detected(long_det),
        .demod_done(done), .demod_abort(abort),
        .long_timeout(long_timeout), .max_pkt_samples(max_pkt),
        .sync_short_reset(sr), .sync_short_enable(se),
        .sync_long_reset(lr), .sync_long_enable(le),
        .demod_is_ongoing(demod), .state(state),
        .pkt_count(pkt), .false_trigger_count(fals), .abort_count(abrt)
    );

    sync_ctrl #(.RESET_CYCLES(5), .CNT_WIDTH(2)) u_small (
        .clock(clock), .reset(reset), .enable(enable), .sample_in_strobe(strobe),
        .short_preamble_detected(short_det), .long_preamble_detected(long_det),
        .demod_done(done), .demod_abort(abort),
        .long_timeout(long_timeout), .max_pkt_samples(max_pkt),
        .sync_short_reset(s_sr), .sync_short_enable(s_se),
        .sync_long_reset(s_lr), .sync_long_enable(s_le),
        .demod_is_ongoing(s_demod), .state(s_state),
        .pkt_count(s_pkt), .false_trigger_count(s_fals), .abort_count(s_abrt)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_short;
        short_det = 1'b1; tick; short_det = 1'b0;
    endtask

    task automatic pulse_long;
        long_det = 1'b1; tick; long_det = 1'b0;
    endtask

    task automatic pulse_done;
        done = 1'b1; tick; done = 1'b0;
    endtask

    // One strobed cycle followed by one idle cycle per sample.
    task automatic samples(input int n);
        repeat (n) begin
            strobe = 1'b1; tick; strobe = 1'b0; tick;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1;
        repeat (3) tick;
        n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_checks++; if ({sr, lr, se, le, demod} !== 5'b11000) $display("FAIL reset_ctrl: got %b want 11000", {sr, lr, se, le, demod}); else n_pass++;
        n_checks++; if ({pkt, fals, abrt} !== 48'd0) $display("FAIL reset_counts: got %h want 0", {pkt, fals, abrt}); else n_pass++;
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            n_checks++; if ({state, sr, lr} !== 4'b0011) $display("FAIL flush_hold cyc%0d: got %b want 0011", i, {state, sr, lr}); else n_pass++;
        end
        tick;
        n_checks++; if (state !== 2'd1) $display("FAIL rearm_state: got %0d want 1", state); else n_pass++;
        n_checks++; if ({sr, lr, se, le, demod} !== 5'b01100) $display("FAIL search_ctrl: got %b want 01100", {sr, lr, se, le, demod}); else n_pass++;
    endtask

    task automatic test_packet;
        pulse_done;
        n_checks++; if ({state, pkt} !== {2'd1, 16'd0}) $display("FAIL done_in_search: got %0d/%0d want 1/0", state, pkt); else n_pass++;
        pulse_short;
        n_checks++; if (state !== 2'd2) $display("FAIL to_wait_long: got %0d want 2", state); else n_pass++;
        n_checks++; if ({sr, lr, se, le, demod} !== 5'b00110) $display("FAIL wait_ctrl: got %b want 00110", {sr, lr, se, le, demod}); else n_pass++;
        samples(200);
        pulse_short;
        n_checks++; if (state !== 2'd2) $display("FAIL short_ignored: got %0d want 2", state); else n_pass++;
        pulse_long;
        n_checks++; if ({state, demod} !== 3'b111) $display("FAIL to_demod: got %b want 111", {state, demod}); else n_pass++;
        samples(1000);
        n_checks++; if (state !== 2'd3) $display("FAIL demod_hold: got %0d want 3", state); else n_pass++;
        pulse_done;
        exp_pkt++;
        n_checks++; if ({state, demod, sr, lr} !== 5'b00011) $display("FAIL done_flush: got %b want 00011", {state, demod, sr, lr}); else n_pass++;
        n_checks++; if (pkt !== 16'(exp_pkt)) $display("FAIL pkt_count: got %0d want %0d", pkt, exp_pkt); else n_pass++;
        repeat (4) tick;
        n_checks++; if (state !== 2'd0) $display("FAIL flush_len: got %0d want 0", state); else n_pass++;
        tick;
        n_checks++; if ({state, se} !== 3'b011) $display("FAIL rearm_after_pkt: got %b want 011", {state, se}); else n_pass++;
    endtask

    task automatic test_timeout;
        long_timeout = 16'd320;
        pulse_short;
        samples(319);
        n_checks++; if ({state, fals} !== {2'd2, 16'd0}) $display("FAIL pre_timeout: got %0d/%0d want 2/0", state, fals); else n_pass++;
        strobe = 1'b1; tick; strobe = 1'b0;
        exp_fals++;
        n_checks++; if (state !== 2'd0) $display("FAIL timeout_flush: got %0d want 0", state); else n_pass++;
        n_checks++; if (fals !== 16'(exp_fals)) $display("FAIL false_count: got %0d want %0d", fals, exp_fals); else n_pass++;
        repeat (4) tick;
        n_checks++; if (state !== 2'd0) $display("FAIL timeout_flush_len: got %0d want 0", state); else n_pass++;
        tick;
        n_checks++; if (state !== 2'd1) $display("FAIL timeout_rearm: got %0d want 1", state); else n_pass++;
        long_timeout = 16'd0;
    endtask

    task automatic test_done_abort;
        pulse_short;
        pulse_long;
        n_checks++; if (state !== 2'd3) $display("FAIL da_enter_demod: got %0d want 3", state); else n_pass++;
        done = 1'b1; abort = 1'b1; tick; done = 1'b0; abort = 1'b0;
        exp_abrt++;
        n_checks++; if ({state, demod} !== 3'b000) $display("FAIL da_flush: got %b want 000", {state, demod}); else n_pass++;
        n_checks++; if ({abrt, pkt} !== {16'(exp_abrt), 16'(exp_pkt)}) $display("FAIL da_counts: got abort %0d pkt %0d want %0d %0d", abrt, pkt, exp_abrt, exp_pkt); else n_pass++;
        repeat (5) tick;
        n_checks++; if (state !== 2'd1) $display("FAIL da_rearm: got %0d want 1", state); else n_pass++;
    endtask

    task automatic test_watchdog;
        max_pkt = 24'd500;
        pulse_short;
        pulse_long;
        samples(499);
        n_checks++; if ({state, abrt} !== {2'd3, 16'(exp_abrt)}) $display("FAIL pre_watchdog: got %0d/%0d want 3/%0d", state, abrt, exp_abrt); else n_pass++;
        strobe = 1'b1; tick; strobe = 1'b0;
        exp_abrt++;
        n_checks++; if ({state, abrt} !== {2'd0, 16'(exp_abrt)}) $display("FAIL watchdog_flush: got %0d/%0d want 0/%0d", state, abrt, exp_abrt); else n_pass++;
        max_pkt = 24'd0;
        repeat (5) tick;
        pulse_short;
        strobe = 1'b1;
        repeat (20000) tick;
        strobe = 1'b0;
        n_checks++; if ({state, fals} !== {2'd2, 16'(exp_fals)}) $display("FAIL no_timeout_hold: got %0d/%0d want 2/%0d", state, fals, exp_fals); else n_pass++;
        pulse_long;
        pulse_done;
        exp_pkt++;
        repeat (5) tick;
        n_checks++; if ({state, pkt} !== {2'd1, 16'(exp_pkt)}) $display("FAIL long_window_pkt: got %0d/%0d want 1/%0d", state, pkt, exp_pkt); else n_pass++;
    endtask

    task automatic test_enable_freeze;
        pulse_short;
        samples(100);
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            strobe   = 1'b1;
            long_det = (i == 25);
            tick;
        end
        strobe = 1'b0; long_det = 1'b0;
        n_checks++; if ({state, se, le, demod} !== 5'b10110) $display("FAIL freeze_state: got %b want 10110", {state, se, le, demod}); else n_pass++;
        n_checks++; if ({pkt, fals, abrt} !== {16'(exp_pkt), 16'(exp_fals), 16'(exp_abrt)}) $display("FAIL freeze_counts: got %h", {pkt, fals, abrt}); else n_pass++;
        enable = 1'b1;
        long_timeout = 16'd150;
        samples(49);
        n_checks++; if (state !== 2'd2) $display("FAIL freeze_timer_hold: got %0d want 2", state); else n_pass++;
        strobe = 1'b1; tick; strobe = 1'b0;
        exp_fals++;
        n_checks++; if ({state, fals} !== {2'd0, 16'(exp_fals)}) $display("FAIL freeze_timer_expire: got %0d/%0d want 0/%0d", state, fals, exp_fals); else n_pass++;
        long_timeout = 16'd0;
        enable = 1'b0;
        repeat (10) tick;
        enable = 1'b1;
        repeat (4) tick;
        n_checks++; if (state !== 2'd0) $display("FAIL freeze_flush_count: got %0d want 0", state); else n_pass++;
        tick;
        n_checks++; if (state !== 2'd1) $display("FAIL freeze_flush_rearm: got %0d want 1", state); else n_pass++;
    endtask

    task automatic test_back_to_back;
        repeat (3) begin
            pulse_short;
            pulse_long;
            pulse_done;
            exp_pkt++;
            repeat (5) tick;
        end
        n_checks++; if ({state, pkt} !== {2'd1, 16'(exp_pkt)}) $display("FAIL b2b_pkt: got %0d/%0d want 1/%0d", state, pkt, exp_pkt); else n_pass++;
        n_checks++; if (s_pkt !== 2'((exp_pkt > 3) ? 3 : exp_pkt)) $display("FAIL sat_pkt: got %0d want %0d", s_pkt, (exp_pkt > 3) ? 3 : exp_pkt); else n_pass++;
        n_checks++; if (s_fals !== 2'((exp_fals > 3) ? 3 : exp_fals)) $display("FAIL sat_false: got %0d want %0d", s_fals, (exp_fals > 3) ? 3 : exp_fals); else n_pass++;
        n_checks++; if (s_abrt !== 2'((exp_abrt > 3) ? 3 : exp_abrt)) $display("FAIL sat_abort: got %0d want %0d", s_abrt, (exp_abrt > 3) ? 3 : exp_abrt); else n_pass++;
        n_checks++; if ({s_state, s_sr, s_se, s_lr, s_le, s_demod} !== 7'b0101100) $display("FAIL small_ctrl: got %b want 0101100", {s_state, s_sr, s_se, s_lr, s_le, s_demod}); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; strobe = 1'b0;
        short_det = 1'b0; long_det = 1'b0; done = 1'b0; abort = 1'b0;
        long_timeout = 16'd0; max_pkt = 24'd0;
        test_reset;
        test_packet;
        test_timeout;
        test_done_abort;
        test_watchdog;
        test_enable_freeze;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish want finish by 2 ms");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/sync_ctrl.md
Name: sync_ctrl

Overview:
- Top-level acquisition sequencer for the receive front end.
- Owns the reset and enable of the short-preamble detector and the long-preamble/symbol-sync stage, and generates demod_is_ongoing.
- Arms short detection, opens a bounded window for long-preamble lock, and holds the chain in demod until the decoder finishes or aborts.
- Then flushes both stages with a multi-cycle reset so their internal averaging and delay pipelines restart clean.

Parameters:
- RESET_CYCLES, 5, clock cycles the detector resets are held high on every flush (minimum 1).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  global advance qualifier; low freezes FSM, timers and counters
- sample_in_strobe  in  1  one pulse per baseband sample; all timeouts count these
- short_preamble_detected  in  1  single-cycle pulse from short detector
- long_preamble_detected  in  1  single-cycle pulse from long-sync stage
- demod_done  in  1  pulse: packet fully decoded
- demod_abort  in  1  pulse: decoder error (bad SIGNAL, parity, etc.)
- long_timeout  in  16  samples allowed between short detect and long lock; 0 = no timeout
- max_pkt_samples  in  24  demod watchdog in samples; 0 = disabled
- sync_short_reset  out  1  reset to short detector
- sync_short_enable  out  1  enable to short detector
- sync_long_reset  out  1  reset to long-sync stage
- sync_long_enable  out  1  enable to long-sync stage
- demod_is_ongoing  out  1  high from long lock until packet end; freezes short-detector phase offset
- state  out  2  current FSM state (debug)
- pkt_count  out  CNT_WIDTH  completed packets, saturating
- false_trigger_count  out  CNT_WIDTH  long-lock timeouts, saturating
- abort_count  out  CNT_WIDTH  demod aborts plus watchdog expiries, saturating

Behaviour:
- All outputs registered.
- On reset:
  - state=S_FLUSH (0); flush counter=0.
  - sync_short_reset=1, sync_long_reset=1; both enables=0; demod_is_ongoing=0.
  - All counters 0; sample timer=0.
- S_FLUSH (0):
  - Both resets high, both enables low; counts clock cycles (not samples).
  - After RESET_CYCLES cycles in state, transition to S_SEARCH.
  - Resets deassert, and sync_short_enable asserts, on the same edge as the state change.
- S_SEARCH (1):
  - sync_short_enable=1, sync_long_enable=0, sync_long_reset=1.
  - short_preamble_detected -> S_WAIT_LONG: sample timer cleared, sync_long_reset deasserts and sync_long_enable asserts next cycle.
- S_WAIT_LONG (2):
  - Both enables=1.
  - Timer increments on sample_in_strobe.
  - Further short-detect pulses are ignored.
  - long_preamble_detected -> S_DEMOD: demod_is_ongoing=1 next cycle, timer cleared.
  - If long_timeout!=0 and timer reaches long_timeout (timer==long_timeout-1 with a strobe present) -> S_FLUSH, false_trigger_count++.
  - Long detect and timeout in the same cycle: long detect wins.
- S_DEMOD (3):
  - demod_is_ongoing=1; both enables stay 1; timer counts samples.
  - demod_done -> S_FLUSH, pkt_count++.
  - demod_abort -> S_FLUSH, abort_count++.
  - done and abort together: abort wins; only abort_count increments.
  - Watchdog: max_pkt_samples!=0 and timer reaches it -> S_FLUSH, abort_count++.
  - demod_is_ongoing drops on the same edge as entry to S_FLUSH.
- enable=0:
  - No state change, no timer or counter update.
  - Outputs hold their values.
  - Event pulses arriving while enable=0 are lost (not queued).
- Counters saturate at all-ones and never wrap.
- long_timeout and max_pkt_samples are sampled live; changing them mid-window takes effect on the next comparison.
- Pulses on inputs that are not relevant to the current state are ignored, e.g. demod_done in S_SEARCH.
- Latency: every transition is one clock edge after the qualifying input cycle. Output changes appear on that same edge.

Test Plan:
- Reset for 3 cycles, release with enable=1 -> both resets high exactly 5 cycles after release, then state=1, sync_short_enable=1, sync_long_enable=0.
- Short pulse, long pulse 200 samples later, demod_done 1000 samples later -> state 1->2->3->0->1; demod_is_ongoing high only in state 3; pkt_count=1.
- long_timeout=320, short pulse, no long pulse -> flush at sample 320; false_trigger_count=1; re-arm after 5 cycles.
- In state 3, demod_done and demod_abort in the same cycle -> abort_count=1, pkt_count=0, flush entered.
- max_pkt_samples=500 with no done/abort -> flush after 500 samples, abort_count=1; repeat with long_timeout=0 and no long pulse for 100000 samples -> state stays 2.
- Hold enable=0 for 50 cycles mid-S_WAIT_LONG, injecting a long pulse -> state, timer and counters unchanged; preload a counter to 0xFFFF and add an event -> it stays 0xFFFF.
